// File: rtl/fetch_if.sv
// Instruction-memory port between the fetch stage (master) and the
// instruction memory (slave): a valid/ready request channel and a response
// channel that is never back-pressured.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

interface fetch_if;
  logic                 imem_req_valid;
  logic [`ADDR_SIZE:0]  imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_resp_valid;
  logic [`INSTR_SIZE:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage. Holds the PC, keeps at most one request in flight
// to instruction memory, and registers {PC, instr, valid} into decode.
// A one-entry skid buffer catches a response that lands while decode stalls;
// redirects squash the in-flight response and any buffered instruction.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module fetch #(
  parameter logic [`ADDR_SIZE:0] RESET_PC = '0,
  parameter logic [`ADDR_SIZE:0] PC_STEP  = 'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_if.master              imem,
  input  logic                 redirect,
  input  logic [`ADDR_SIZE:0]  redirect_pc,
  input  logic                 stall,
  output logic [`ADDR_SIZE:0]  PC_out,
  output logic [`INSTR_SIZE:0] instr_out,
  output logic                 pipeline_out_valid
);

  // S_REQ: request out; S_WAIT: awaiting response; S_FULL: response parked
  // in skid buffer; S_DROP: awaiting a response that must be thrown away.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

  state_t               state_q, state_d;
  logic [`ADDR_SIZE:0]  pc;
  logic [`ADDR_SIZE:0]  req_pc;
  logic [`ADDR_SIZE:0]  skid_pc;
  logic [`INSTR_SIZE:0] skid_instr;
  logic                 accept;
  logic                 resp_in;
  logic                 wait_resp;

  assign accept    = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_in   = imem.imem_resp_valid;
  assign wait_resp = (state_q == S_WAIT) && resp_in;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Next-state logic; a redirect outranks stall and response handling.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    if (redirect) begin
      unique case (state_q)
        S_REQ:  state_d = accept  ? S_DROP : S_REQ;
        S_WAIT: state_d = resp_in ? S_REQ  : S_DROP;
        S_FULL: state_d = S_REQ;
        S_DROP: state_d = resp_in ? S_REQ  : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ:  if (accept)  state_d = S_WAIT;
        S_WAIT: if (resp_in) state_d = stall ? S_FULL : S_REQ;
        S_FULL: if (!stall)  state_d = S_REQ;
        S_DROP: if (resp_in) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Request-port outputs: request only from S_REQ and never under reset.
  always_comb begin
    imem.imem_req_valid = (state_q == S_REQ) && !reset;
    imem.imem_req_addr  = pc;
  end

  // PC and decode-facing output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc                 <= RESET_PC;
      PC_out             <= '0;
      instr_out          <= '0;
      pipeline_out_valid <= 1'b0;
    end else begin
      if (redirect)    pc <= redirect_pc;
      else if (accept) pc <= pc + PC_STEP;

      if (redirect) begin
        pipeline_out_valid <= 1'b0;
      end else if (!stall) begin
        if (wait_resp) begin
          PC_out             <= req_pc;
          instr_out          <= imem.imem_resp_data;
          pipeline_out_valid <= 1'b1;
        end else if (state_q == S_FULL) begin
          PC_out             <= skid_pc;
          instr_out          <= skid_instr;
          pipeline_out_valid <= 1'b1;
        end else begin
          pipeline_out_valid <= 1'b0;
        end
      end
    end
  end

  // In-flight PC and skid buffer; pure data, qualified by state_q.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are deliberately not reset; the FSM never
    // reads them until a request or a stalled response has written them.
    if (accept) req_pc <= pc;
    if (wait_resp && stall && !redirect) begin
      skid_pc    <= req_pc;
      skid_instr <= imem.imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: directed scenarios followed by a
// randomized run scored against a transaction-level program-order model.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module tb_fetch;
  localparam logic [31:0] MAGIC = 32'h0000_00A5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 redirect;
  logic [`ADDR_SIZE:0]  redirect_pc;
  logic                 stall;
  logic [`ADDR_SIZE:0]  PC_out;
  logic [`INSTR_SIZE:0] instr_out;
  logic                 pipeline_out_valid;

  fetch_if bus ();

  fetch dut (
    .clk                (clk),
    .reset              (reset),
    .imem               (bus),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .stall              (stall),
    .PC_out             (PC_out),
    .instr_out          (instr_out),
    .pipeline_out_valid (pipeline_out_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state: one pending response with a latency countdown.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory samples the request mid-cycle, then after the
  // edge drives any response that has come due.
  task automatic tick();
    @(negedge clk);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = bus.imem_req_addr;
      pend_cnt  = lat;
    end
    @(posedge clk);
    #1;
    bus.imem_resp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = pend_addr ^ MAGIC;
        pend                = 1'b0;
      end
    end
    #1;
  endtask

  // Accept cycle then response cycle: a bubble, then the instruction.
  task automatic deliver_one(input logic [31:0] exp_pc);
    tick();
    check("bubble_after_accept", pipeline_out_valid, 0);
    tick();
    check("deliver_valid", pipeline_out_valid, 1);
    check("deliver_pc", PC_out, exp_pc);
    check("deliver_instr", instr_out, exp_pc ^ MAGIC);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    check("req_valid_in_reset", bus.imem_req_valid, 0);
    tick();
    tick();
    check("reset_valid", pipeline_out_valid, 0);
    check("reset_pc_out", PC_out, 0);
    check("reset_instr", instr_out, 0);
    reset = 1'b0;
    #1;
    check("reset_req_addr", bus.imem_req_addr, 0);
  endtask

  // Random-phase model variables.
  logic [31:0] fetch_pc, exp_pc, p_pc, p_instr;
  logic        p_valid, s_stall, s_redir;
  int          deliveries;

  initial begin
    reset               = 1'b1;
    redirect            = 1'b0;
    redirect_pc         = '0;
    stall               = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;

    // 1: back-to-back fetch, one instruction every two cycles.
    reset_dut();
    check("req_valid_after_reset", bus.imem_req_valid, 1);
    for (int i = 0; i < 4; i++) deliver_one(32'(4 * i));

    // 2: stall when the response for PC 8 lands; outputs hold, no request.
    reset_dut();
    deliver_one(32'h0);
    deliver_one(32'h4);
    tick();                      // accept PC 8
    stall = 1'b1;                // response for PC 8 arrives this cycle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", PC_out, 32'h4);
      check("stall_hold_valid", pipeline_out_valid, 0);
      check("stall_no_req", bus.imem_req_valid, 0);
    end
    stall = 1'b0;
    tick();
    check("unstall_valid", pipeline_out_valid, 1);
    check("unstall_pc", PC_out, 32'h8);
    check("unstall_instr", instr_out, 32'h8 ^ MAGIC);
    check("unstall_req_addr", bus.imem_req_addr, 32'hC);
    deliver_one(32'hC);

    // 3: redirect while waiting (PC 0x10 in flight), response two cycles late.
    lat = 2;
    tick();                      // accept 0x10
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("drop_valid", pipeline_out_valid, 0);
    check("drop_no_req", bus.imem_req_valid, 0);
    tick();                      // stale response discarded here
    check("drop_resp_valid", pipeline_out_valid, 0);
    check("redir_req_valid", bus.imem_req_valid, 1);
    check("redir_req_addr", bus.imem_req_addr, 32'h100);
    lat = 1;
    deliver_one(32'h100);

    // 4: redirect in the same cycle as the response.
    tick();                      // accept 0x104
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("redir_resp_valid", pipeline_out_valid, 0);
    check("redir_resp_req", bus.imem_req_valid, 1);
    check("redir_resp_addr", bus.imem_req_addr, 32'h40);
    deliver_one(32'h40);

    // 5: memory not ready for four cycles.
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("notready_req_valid", bus.imem_req_valid, 1);
      check("notready_addr", bus.imem_req_addr, 32'h44);
      check("notready_bubble", pipeline_out_valid, 0);
    end
    bus.imem_req_ready = 1'b1;
    deliver_one(32'h44);

    // 6: reset while waiting; late response must be ignored; PC wraps.
    lat = 3;
    tick();                      // accept 0x48
    reset = 1'b1;
    #1;
    check("reset_wait_req", bus.imem_req_valid, 0);
    tick();
    reset              = 1'b0;
    bus.imem_req_ready = 1'b0;   // hold off until the late response passes
    #1;
    check("rst_wait_pc_out", PC_out, 0);
    check("rst_wait_valid", pipeline_out_valid, 0);
    check("rst_wait_addr", bus.imem_req_addr, 0);
    tick();                      // late response arrives in this cycle
    tick();
    check("late_resp_ignored", pipeline_out_valid, 0);
    check("late_resp_addr", bus.imem_req_addr, 0);
    check("late_resp_req", bus.imem_req_valid, 1);
    bus.imem_req_ready = 1'b1;
    lat = 1;
    deliver_one(32'h0);
    check("pc_after_accept", bus.imem_req_addr, 32'h4);
    bus.imem_req_ready = 1'b0;
    redirect           = 1'b1;
    redirect_pc        = 32'hFFFF_FFFC;
    tick();
    redirect           = 1'b0;
    bus.imem_req_ready = 1'b1;
    check("wrap_start_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    deliver_one(32'hFFFF_FFFC);
    check("wrap_addr", bus.imem_req_addr, 32'h0);

    // Random phase: program-order model of fetch addresses and deliveries.
    fetch_pc   = 32'h0;
    exp_pc     = 32'h0;
    deliveries = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      stall              = ($urandom_range(3) == 0);
      bus.imem_req_ready = ($urandom_range(3) != 0);
      redirect           = ($urandom_range(19) == 0);
      redirect_pc        = $urandom & 32'hFFFF_FFFC;
      lat                = int'($urandom_range(3, 1));
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("rand_req_addr", bus.imem_req_addr, fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
      end
      if (redirect) fetch_pc = redirect_pc;
      p_pc    = PC_out;
      p_instr = instr_out;
      p_valid = pipeline_out_valid;
      s_stall = stall;
      s_redir = redirect;
      tick();
      redirect = 1'b0;
      if (s_redir) begin
        check("rand_redir_valid", pipeline_out_valid, 0);
        exp_pc = redirect_pc;
      end else if (s_stall) begin
        check("rand_stall_hold", {PC_out, instr_out}, {p_pc, p_instr});
        check("rand_stall_valid", pipeline_out_valid, p_valid);
      end else if (pipeline_out_valid) begin
        check("rand_pc", PC_out, exp_pc);
        check("rand_instr", instr_out, exp_pc ^ MAGIC);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end
    check("rand_progress", deliveries >= 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
